// File: rtl/crtc_regfile_if.sv
// CRTC register file bus bundle: the 6545-style CPU port and the pipelined
// Wishbone peripheral port. Signal names keep the register file's pin names so
// the board-level netlist maps one-to-one.
interface crtc_regfile_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int INDEX_WIDTH = 5
) ();

  // CPU (6545-style) bus
  logic                   crtc_clk_en_i;
  logic                   crtc_cs_i;
  logic                   crtc_we_i;
  logic                   crtc_rs_i;
  logic [DATA_WIDTH-1:0]  crtc_data_i;
  logic [DATA_WIDTH-1:0]  crtc_data_o;
  logic                   crtc_data_oe;

  // Pipelined Wishbone slave
  logic [INDEX_WIDTH-1:0] wb_addr_i;
  logic [DATA_WIDTH-1:0]  wb_data_i;
  logic [DATA_WIDTH-1:0]  wb_data_o;
  logic                   wb_we_i;
  logic                   wb_cycle_i;
  logic                   wb_strobe_i;
  logic                   wb_stall_o;
  logic                   wb_ack_o;

  // Register-file side
  modport slave (
    input  crtc_clk_en_i, crtc_cs_i, crtc_we_i, crtc_rs_i, crtc_data_i,
    output crtc_data_o, crtc_data_oe,
    input  wb_addr_i, wb_data_i, wb_we_i, wb_cycle_i, wb_strobe_i,
    output wb_data_o, wb_stall_o, wb_ack_o
  );

  // CPU / MCU side
  modport master (
    output crtc_clk_en_i, crtc_cs_i, crtc_we_i, crtc_rs_i, crtc_data_i,
    input  crtc_data_o, crtc_data_oe,
    output wb_addr_i, wb_data_i, wb_we_i, wb_cycle_i, wb_strobe_i,
    input  wb_data_o, wb_stall_o, wb_ack_o
  );

endinterface

// File: rtl/crtc_regfile.sv
// CRTC timing register file shared by the CPU bus and a pipelined Wishbone
// port. Registers are stored pre-masked, so unimplemented bits always read 0
// on every port and on the flat regs_o vector feeding the timing generator.
// Writes from both ports land at the same clock edge; on a same-register
// collision the CPU value wins. Wishbone reads sample the register at the
// accept edge and return it ACK_LATENCY cycles later.
module crtc_regfile #(
  parameter int NUM_REGS    = 18,
  parameter int DATA_WIDTH  = 8,
  parameter int INDEX_WIDTH = 5,
  parameter int ACK_LATENCY = 1,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] REG_MASK     = {NUM_REGS*DATA_WIDTH{1'b1}},
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALUES = '0
) (
  input  logic                           wb_clock_i,
  input  logic                           wb_reset_i,
  crtc_regfile_if.slave                  bus,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            reg_changed_o
);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } wb_state_t;

  // Counter reload: cycles still to wait after the accept edge.
  localparam logic [2:0] CNT_LOAD = 3'(ACK_LATENCY - 1);

  // Register storage and change pulses
  logic [DATA_WIDTH-1:0]  r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]    r_changed;

  // CPU index register (write-only from the CPU)
  logic [INDEX_WIDTH-1:0] r_index;

  // Wishbone transaction state
  wb_state_t              r_state;
  logic [2:0]             r_cnt;
  logic [DATA_WIDTH-1:0]  r_rdata;
  logic [DATA_WIDTH-1:0]  r_wb_data;
  logic                   r_ack;
  logic                   r_stall;

  // Decoded strobes and read muxes
  logic                   w_cpu_cycle;
  logic                   w_cpu_idx_wr;
  logic                   w_cpu_dat_wr;
  logic                   w_cpu_rd_sel;
  logic                   w_wb_accept;
  logic                   w_wb_wr;
  logic [NUM_REGS-1:0]    w_cpu_hit;
  logic [NUM_REGS-1:0]    w_wb_hit;
  logic [DATA_WIDTH-1:0]  w_cpu_rd_mux;
  logic [DATA_WIDTH-1:0]  w_wb_rd_mux;
  logic [DATA_WIDTH-1:0]  w_wb_capture;

  assign w_cpu_cycle  = bus.crtc_clk_en_i & bus.crtc_cs_i;
  assign w_cpu_idx_wr = w_cpu_cycle & ~bus.crtc_rs_i & bus.crtc_we_i;
  assign w_cpu_dat_wr = w_cpu_cycle &  bus.crtc_rs_i & bus.crtc_we_i;

  // Data-register read is decoded from chip select alone, not the bus strobe,
  // so the CPU sees stable data for the whole access.
  assign w_cpu_rd_sel = bus.crtc_cs_i & bus.crtc_rs_i & ~bus.crtc_we_i & ~wb_reset_i;

  assign w_wb_accept  = (r_state == ST_IDLE) & bus.wb_cycle_i & bus.wb_strobe_i;
  assign w_wb_wr      = w_wb_accept & bus.wb_we_i;

  // Read muxes: an index with no matching register falls through to 0.
  always_comb begin
    // NOTE: every comb output gets a default before the loop, so no path can
    // leave it unassigned and infer a latch.
    w_cpu_rd_mux = '0;
    w_wb_rd_mux  = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (r_index == INDEX_WIDTH'(k))       w_cpu_rd_mux = r_regs[k];
      if (bus.wb_addr_i == INDEX_WIDTH'(k)) w_wb_rd_mux  = r_regs[k];
    end
  end

  // Per-register write hits; out-of-range indices simply match nothing.
  always_comb begin
    w_cpu_hit = '0;
    w_wb_hit  = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      w_cpu_hit[k] = w_cpu_dat_wr & (r_index == INDEX_WIDTH'(k));
      w_wb_hit[k]  = w_wb_wr & (bus.wb_addr_i == INDEX_WIDTH'(k));
    end
  end

  // Writes return 0 on the Wishbone data bus.
  assign w_wb_capture = bus.wb_we_i ? '0 : w_wb_rd_mux;

  // Register array: reset values, masked writes from both ports, change pulses.
  always_ff @(posedge wb_clock_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (wb_reset_i) begin
      // NOTE: this array is a small bank of flops, not a RAM, so it can carry
      // per-register reset values; a RAM-mapped array must not be reset.
      for (int k = 0; k < NUM_REGS; k++) begin
        r_regs[k] <= RESET_VALUES[k*DATA_WIDTH +: DATA_WIDTH] &
                     REG_MASK[k*DATA_WIDTH +: DATA_WIDTH];
      end
      r_changed <= '0;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (w_cpu_hit[k]) begin
          r_regs[k] <= bus.crtc_data_i & REG_MASK[k*DATA_WIDTH +: DATA_WIDTH];
        end else if (w_wb_hit[k]) begin
          r_regs[k] <= bus.wb_data_i & REG_MASK[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      // A collision sets the same bit once; pulses fire even for an
      // unchanged value.
      r_changed <= w_cpu_hit | w_wb_hit;
    end
  end

  // CPU index register, loaded by an address-register write.
  always_ff @(posedge wb_clock_i) begin
    if (wb_reset_i) begin
      r_index <= '0;
    end else if (w_cpu_idx_wr) begin
      r_index <= bus.crtc_data_i[INDEX_WIDTH-1:0];
    end
  end

  // Wishbone FSM: accept in IDLE, count down in WAIT, single-cycle ack with
  // stall held through the ack cycle; dropping cycle aborts without an ack.
  always_ff @(posedge wb_clock_i) begin
    if (wb_reset_i) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_rdata   <= '0;
      r_wb_data <= '0;
      r_ack     <= 1'b0;
      r_stall   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ack     <= 1'b0;
          r_wb_data <= '0;
          r_stall   <= 1'b0;
          if (w_wb_accept) begin
            r_state <= ST_WAIT;
            r_stall <= 1'b1;
            r_cnt   <= CNT_LOAD;
            r_rdata <= w_wb_capture;
            if (ACK_LATENCY == 1) begin
              r_ack     <= 1'b1;
              r_wb_data <= w_wb_capture;
            end
          end
        end
        ST_WAIT: begin
          if (!bus.wb_cycle_i || r_ack) begin
            r_state   <= ST_IDLE;
            r_ack     <= 1'b0;
            r_wb_data <= '0;
            r_stall   <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 3'd1;
            if (r_cnt == 3'd1) begin
              r_ack     <= 1'b1;
              r_wb_data <= r_rdata;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ack   <= 1'b0;
          r_stall <= 1'b0;
        end
      endcase
    end
  end

  // Flat export to the timing generator; storage is already masked.
  always_comb begin
    regs_o = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      regs_o[k*DATA_WIDTH +: DATA_WIDTH] = r_regs[k];
    end
  end

  assign reg_changed_o    = r_changed;
  assign bus.crtc_data_o  = w_cpu_rd_sel ? w_cpu_rd_mux : '0;
  assign bus.crtc_data_oe = w_cpu_rd_sel;
  assign bus.wb_data_o    = r_wb_data;
  assign bus.wb_ack_o     = r_ack;
  assign bus.wb_stall_o   = r_stall;

endmodule

// File: tb/tb_crtc_regfile.sv
// Directed bench for crtc_regfile. u_dut runs with ACK_LATENCY=3, reset
// values R0=49/R1=40/R9=7 and R10 masked to 7 bits; u_dut1 runs the default
// single-cycle ack configuration.
module tb_crtc_regfile;

  localparam int NR = 18;
  localparam logic [NR*8-1:0] MASK = ~(144'h80 << 80);
  localparam logic [NR*8-1:0] RSTV = 144'd49 | (144'd40 << 8) | (144'd7 << 72);

  logic             clk = 1'b0;
  logic             rst;
  logic [NR*8-1:0]  regs;
  logic [NR-1:0]    chg;
  logic [NR*8-1:0]  regs1;
  logic [NR-1:0]    chg1;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_r [NR];
  int         pulse_cnt [NR];

  crtc_regfile_if #(.DATA_WIDTH(8), .INDEX_WIDTH(5)) bus  ();
  crtc_regfile_if #(.DATA_WIDTH(8), .INDEX_WIDTH(5)) bus1 ();

  crtc_regfile #(
    .NUM_REGS(NR), .DATA_WIDTH(8), .INDEX_WIDTH(5), .ACK_LATENCY(3),
    .REG_MASK(MASK), .RESET_VALUES(RSTV)
  ) u_dut (
    .wb_clock_i(clk), .wb_reset_i(rst), .bus(bus),
    .regs_o(regs), .reg_changed_o(chg)
  );

  crtc_regfile #(
    .NUM_REGS(NR), .DATA_WIDTH(8), .INDEX_WIDTH(5), .ACK_LATENCY(1)
  ) u_dut1 (
    .wb_clock_i(clk), .wb_reset_i(rst), .bus(bus1),
    .regs_o(regs1), .reg_changed_o(chg1)
  );

  always #5 clk = ~clk;

  // Count change pulses of u_dut away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NR; k++) if (chg[k]) pulse_cnt[k]++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pulses();
    for (int k = 0; k < NR; k++) pulse_cnt[k] = 0;
  endtask

  task automatic exp_reset();
    for (int k = 0; k < NR; k++) exp_r[k] = 8'h00;
    exp_r[0] = 8'd49;
    exp_r[1] = 8'd40;
    exp_r[9] = 8'd7;
  endtask

  function automatic logic [NR*8-1:0] exp_flat();
    logic [NR*8-1:0] v;
    for (int k = 0; k < NR; k++) v[k*8 +: 8] = exp_r[k];
    return v;
  endfunction

  task automatic idle_inputs();
    bus.crtc_clk_en_i = 0; bus.crtc_cs_i = 0; bus.crtc_we_i = 0; bus.crtc_rs_i = 0;
    bus.crtc_data_i = '0; bus.wb_addr_i = '0; bus.wb_data_i = '0; bus.wb_we_i = 0;
    bus.wb_cycle_i = 0; bus.wb_strobe_i = 0;
    bus1.crtc_clk_en_i = 0; bus1.crtc_cs_i = 0; bus1.crtc_we_i = 0; bus1.crtc_rs_i = 0;
    bus1.crtc_data_i = '0; bus1.wb_addr_i = '0; bus1.wb_data_i = '0; bus1.wb_we_i = 0;
    bus1.wb_cycle_i = 0; bus1.wb_strobe_i = 0;
  endtask

  // One CPU write strobe; the write lands at the edge this task steps over.
  task automatic cpu_write(input logic rs, input logic [7:0] data);
    bus.crtc_clk_en_i = 1; bus.crtc_cs_i = 1; bus.crtc_we_i = 1;
    bus.crtc_rs_i = rs; bus.crtc_data_i = data;
    step();
    bus.crtc_clk_en_i = 0; bus.crtc_cs_i = 0; bus.crtc_we_i = 0;
  endtask

  // Called right after the accept edge with strobe already low: waits
  // (bounded) for ack, then ends the cycle. lat=0 means no ack arrived.
  task automatic wait_ack(output int lat, output logic [7:0] rdata);
    lat = 0;
    rdata = 8'hxx;
    for (int i = 1; i <= 8; i++) begin
      if (bus.wb_ack_o) begin
        lat = i;
        rdata = bus.wb_data_o;
        break;
      end
      step();
    end
    bus.wb_cycle_i = 0;
    step();
  endtask

  task automatic wb_xfer(input logic we, input logic [4:0] addr, input logic [7:0] wdata,
                         output logic [7:0] rdata, output int lat);
    bus.wb_cycle_i = 1; bus.wb_strobe_i = 1; bus.wb_we_i = we;
    bus.wb_addr_i = addr; bus.wb_data_i = wdata;
    step();
    bus.wb_strobe_i = 0; bus.wb_we_i = 0;
    wait_ack(lat, rdata);
  endtask

  task automatic test_reset();
    logic [4:0] addrs [4] = '{5'd0, 5'd1, 5'd9, 5'd13};
    logic [7:0] exps  [4] = '{8'd49, 8'd40, 8'd7, 8'd0};
    logic [7:0] d;
    int lat;
    rst = 1;
    idle_inputs();
    exp_reset();
    repeat (3) step();
    checks++; if (bus.wb_ack_o !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", bus.wb_ack_o); end
    checks++; if (bus.wb_stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", bus.wb_stall_o); end
    checks++; if (bus.wb_data_o !== 8'h00) begin failures++; $display("FAIL reset_wbdata got=%h exp=00", bus.wb_data_o); end
    checks++; if (chg !== '0) begin failures++; $display("FAIL reset_changed got=%h exp=0", chg); end
    checks++; if (regs !== exp_flat()) begin failures++; $display("FAIL reset_regs got=%h exp=%h", regs, exp_flat()); end
    rst = 0;
    step();
    for (int i = 0; i < 4; i++) begin
      wb_xfer(1'b0, addrs[i], 8'h00, d, lat);
      checks++; if (lat !== 3) begin failures++; $display("FAIL reset_read_lat idx=%0d got=%0d exp=3", addrs[i], lat); end
      checks++; if (d !== exps[i]) begin failures++; $display("FAIL reset_read idx=%0d got=%h exp=%h", addrs[i], d, exps[i]); end
    end
  endtask

  task automatic test_mask();
    logic [7:0] d;
    int lat;
    cpu_write(1'b0, 8'd10);
    clear_pulses();
    cpu_write(1'b1, 8'hFF);
    exp_r[10] = 8'h7F;
    checks++; if (chg !== 18'h00400) begin failures++; $display("FAIL mask_changed got=%h exp=00400", chg); end
    checks++; if (regs[80 +: 8] !== 8'h7F) begin failures++; $display("FAIL mask_regs_o got=%h exp=7f", regs[80 +: 8]); end
    repeat (3) step();
    checks++; if (pulse_cnt[10] !== 1) begin failures++; $display("FAIL mask_pulse_count got=%0d exp=1", pulse_cnt[10]); end
    bus.crtc_cs_i = 1; bus.crtc_rs_i = 1; bus.crtc_we_i = 0;
    #1;
    checks++; if (bus.crtc_data_o !== 8'h7F) begin failures++; $display("FAIL mask_cpu_read got=%h exp=7f", bus.crtc_data_o); end
    checks++; if (bus.crtc_data_oe !== 1'b1) begin failures++; $display("FAIL mask_cpu_oe got=%b exp=1", bus.crtc_data_oe); end
    bus.crtc_cs_i = 0; bus.crtc_rs_i = 0;
    step();
    wb_xfer(1'b0, 5'd10, 8'h00, d, lat);
    checks++; if (d !== 8'h7F) begin failures++; $display("FAIL mask_wb_read got=%h exp=7f", d); end
  endtask

  task automatic test_latency();
    bus.wb_cycle_i = 1; bus.wb_strobe_i = 1; bus.wb_we_i = 0; bus.wb_addr_i = 5'd1;
    checks++; if (bus.wb_stall_o !== 1'b0) begin failures++; $display("FAIL lat_idle_stall got=%b exp=0", bus.wb_stall_o); end
    step();
    bus.wb_strobe_i = 0;
    for (int i = 1; i <= 3; i++) begin
      checks++; if (bus.wb_stall_o !== 1'b1) begin failures++; $display("FAIL lat_stall cyc=N+%0d got=%b exp=1", i, bus.wb_stall_o); end
      checks++; if (bus.wb_ack_o !== (i == 3)) begin failures++; $display("FAIL lat_ack cyc=N+%0d got=%b exp=%b", i, bus.wb_ack_o, (i == 3)); end
      if (i == 3) begin
        checks++; if (bus.wb_data_o !== 8'd40) begin failures++; $display("FAIL lat_data got=%h exp=28", bus.wb_data_o); end
      end
      step();
    end
    checks++; if (bus.wb_stall_o !== 1'b0 || bus.wb_ack_o !== 1'b0) begin
      failures++; $display("FAIL lat_after_ack stall=%b ack=%b exp=0,0", bus.wb_stall_o, bus.wb_ack_o);
    end
    bus.wb_cycle_i = 0;
    step();
  endtask

  task automatic test_collision();
    logic [7:0] d;
    int lat;
    cpu_write(1'b0, 8'd1);
    clear_pulses();
    bus.crtc_clk_en_i = 1; bus.crtc_cs_i = 1; bus.crtc_we_i = 1; bus.crtc_rs_i = 1;
    bus.crtc_data_i = 8'd80;
    bus.wb_cycle_i = 1; bus.wb_strobe_i = 1; bus.wb_we_i = 1;
    bus.wb_addr_i = 5'd1; bus.wb_data_i = 8'd20;
    step();
    bus.crtc_clk_en_i = 0; bus.crtc_cs_i = 0; bus.crtc_we_i = 0;
    bus.wb_strobe_i = 0; bus.wb_we_i = 0;
    exp_r[1] = 8'd80;
    checks++; if (regs[8 +: 8] !== 8'd80) begin failures++; $display("FAIL coll_same_value got=%0d exp=80", regs[8 +: 8]); end
    checks++; if (chg !== 18'h00002) begin failures++; $display("FAIL coll_same_changed got=%h exp=00002", chg); end
    wait_ack(lat, d);
    checks++; if (lat !== 3 || d !== 8'h00) begin failures++; $display("FAIL coll_write_ack lat=%0d data=%h exp=3,00", lat, d); end
    checks++; if (pulse_cnt[1] !== 1) begin failures++; $display("FAIL coll_pulse_count got=%0d exp=1", pulse_cnt[1]); end
    // Different registers in the same cycle: both land.
    bus.crtc_clk_en_i = 1; bus.crtc_cs_i = 1; bus.crtc_we_i = 1; bus.crtc_rs_i = 1;
    bus.crtc_data_i = 8'd5;
    bus.wb_cycle_i = 1; bus.wb_strobe_i = 1; bus.wb_we_i = 1;
    bus.wb_addr_i = 5'd2; bus.wb_data_i = 8'd6;
    step();
    bus.crtc_clk_en_i = 0; bus.crtc_cs_i = 0; bus.crtc_we_i = 0;
    bus.wb_strobe_i = 0; bus.wb_we_i = 0;
    exp_r[1] = 8'd5;
    exp_r[2] = 8'd6;
    checks++; if (chg !== 18'h00006) begin failures++; $display("FAIL coll_diff_changed got=%h exp=00006", chg); end
    checks++; if (regs !== exp_flat()) begin failures++; $display("FAIL coll_diff_regs got=%h exp=%h", regs, exp_flat()); end
    wait_ack(lat, d);
  endtask

  task automatic test_oob_index();
    int total;
    cpu_write(1'b0, 8'd25);
    clear_pulses();
    cpu_write(1'b1, 8'hAA);
    repeat (2) step();
    total = 0;
    for (int k = 0; k < NR; k++) total += pulse_cnt[k];
    checks++; if (total !== 0) begin failures++; $display("FAIL oob_pulses got=%0d exp=0", total); end
    checks++; if (regs !== exp_flat()) begin failures++; $display("FAIL oob_regs got=%h exp=%h", regs, exp_flat()); end
    bus.crtc_cs_i = 1; bus.crtc_rs_i = 1; bus.crtc_we_i = 0;
    #1;
    checks++; if (bus.crtc_data_o !== 8'h00 || bus.crtc_data_oe !== 1'b1) begin
      failures++; $display("FAIL oob_read data=%h oe=%b exp=00,1", bus.crtc_data_o, bus.crtc_data_oe);
    end
    bus.crtc_rs_i = 0;
    #1;
    checks++; if (bus.crtc_data_o !== 8'h00 || bus.crtc_data_oe !== 1'b0) begin
      failures++; $display("FAIL index_read data=%h oe=%b exp=00,0", bus.crtc_data_o, bus.crtc_data_oe);
    end
    bus.crtc_cs_i = 0;
    step();
  endtask

  task automatic test_abort();
    logic [7:0] d;
    int lat;
    bit seen_ack;
    bus.wb_cycle_i = 1; bus.wb_strobe_i = 1; bus.wb_we_i = 0; bus.wb_addr_i = 5'd0;
    step();
    bus.wb_strobe_i = 0;
    bus.wb_cycle_i = 0;
    checks++; if (bus.wb_stall_o !== 1'b1) begin failures++; $display("FAIL abort_stall_wait got=%b exp=1", bus.wb_stall_o); end
    step();
    checks++; if (bus.wb_stall_o !== 1'b0) begin failures++; $display("FAIL abort_stall_low got=%b exp=0", bus.wb_stall_o); end
    seen_ack = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.wb_ack_o) seen_ack = 1;
      step();
    end
    checks++; if (seen_ack !== 1'b0) begin failures++; $display("FAIL abort_no_ack got=%b exp=0", seen_ack); end
    wb_xfer(1'b0, 5'd9, 8'h00, d, lat);
    checks++; if (lat !== 3 || d !== 8'd7) begin failures++; $display("FAIL abort_next_read lat=%0d data=%h exp=3,07", lat, d); end
  endtask

  task automatic test_back_to_back_lat1();
    bus1.wb_cycle_i = 1; bus1.wb_strobe_i = 1; bus1.wb_we_i = 1;
    bus1.wb_addr_i = 5'd3; bus1.wb_data_i = 8'h5A;
    step();
    // Next request is presented during the ack cycle and must wait one cycle.
    bus1.wb_we_i = 0;
    checks++; if (bus1.wb_ack_o !== 1'b1 || bus1.wb_stall_o !== 1'b1) begin
      failures++; $display("FAIL l1_write_ack ack=%b stall=%b exp=1,1", bus1.wb_ack_o, bus1.wb_stall_o);
    end
    checks++; if (regs1[24 +: 8] !== 8'h5A) begin failures++; $display("FAIL l1_write_value got=%h exp=5a", regs1[24 +: 8]); end
    step();
    checks++; if (bus1.wb_ack_o !== 1'b0 || bus1.wb_stall_o !== 1'b0) begin
      failures++; $display("FAIL l1_gap ack=%b stall=%b exp=0,0", bus1.wb_ack_o, bus1.wb_stall_o);
    end
    step();
    bus1.wb_strobe_i = 0;
    checks++; if (bus1.wb_ack_o !== 1'b1 || bus1.wb_data_o !== 8'h5A) begin
      failures++; $display("FAIL l1_read ack=%b data=%h exp=1,5a", bus1.wb_ack_o, bus1.wb_data_o);
    end
    bus1.wb_cycle_i = 0;
    step();
    checks++; if (bus1.wb_ack_o !== 1'b0) begin failures++; $display("FAIL l1_ack_single got=%b exp=0", bus1.wb_ack_o); end
  endtask

  task automatic test_reset_mid();
    bit seen_ack;
    bus.wb_cycle_i = 1; bus.wb_strobe_i = 1; bus.wb_we_i = 1;
    bus.wb_addr_i = 5'd4; bus.wb_data_i = 8'd33;
    step();
    bus.wb_strobe_i = 0; bus.wb_we_i = 0;
    checks++; if (regs[32 +: 8] !== 8'd33) begin failures++; $display("FAIL rmid_write_applied got=%0d exp=33", regs[32 +: 8]); end
    rst = 1;
    seen_ack = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (bus.wb_ack_o) seen_ack = 1;
    end
    exp_reset();
    checks++; if (seen_ack !== 1'b0 || bus.wb_stall_o !== 1'b0) begin
      failures++; $display("FAIL rmid_no_ack ack_seen=%b stall=%b exp=0,0", seen_ack, bus.wb_stall_o);
    end
    checks++; if (regs !== exp_flat()) begin failures++; $display("FAIL rmid_regs got=%h exp=%h", regs, exp_flat()); end
    bus.wb_cycle_i = 0;
    rst = 0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mask();
    test_latency();
    test_collision();
    test_oob_index();
    test_abort();
    test_back_to_back_lat1();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
